enigma_char_feeder: RTL

Upstream front-end for the Enigma core: it accepts a stream of ASCII characters, case-folds letters to the core's 0–25 alphabet index, and buffers them in a small FIFO. It issues one character at a time to the core's valid/din/dec inputs, waits for the core's done pulse, and converts the returned index back to uppercase ASCII on a ready/valid output. Non-letters are dropped and counted. A watchdog guards against a core that never answers.

---
 rtl/enigma_char_feeder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/enigma_char_feeder.sv
// enigma_char_feeder: ASCII front-end for the Enigma core.
// Letters are case-folded to 0..25 and queued with their decrypt flag; a
// single character at a time is issued to the core, and the result is
// returned as uppercase ASCII on a ready/valid port. Non-letters are dropped
// and counted, and a watchdog abandons characters the core never answers.
//
// state | meaning
// IDLE  | waiting for a queued character; pops the head entry on exit
// ISSUE | core_valid pulse, watchdog loaded
// WAIT  | waiting for core_done or the watchdog terminal count
// OUT   | out_char presented until out_ready
module enigma_char_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic        in_dec,
  output logic        core_valid,
  output logic [7:0]  core_din,
  output logic        core_dec,
  input  logic        core_done,
  input  logic [7:0]  core_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        err_timeout,
  output logic [15:0] drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t        state, state_nxt;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, accept, is_upper, is_lower, is_letter, push, pop;
  logic [7:0]    letter_idx;
  logic [7:0]    result_char;
  logic [TW-1:0] timer;
  logic          timer_tc;

  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign accept     = in_valid && !full;
  assign is_upper   = (in_char >= 8'h41) && (in_char <= 8'h5A);
  assign is_lower   = (in_char >= 8'h61) && (in_char <= 8'h7A);
  assign is_letter  = is_upper || is_lower;
  assign push       = accept && is_letter;
  assign letter_idx = is_upper ? (in_char - 8'h41) : (in_char - 8'h61);

  // Out-of-alphabet core results come back as '?'
  assign result_char = (core_dout <= 8'd25) ? (8'h41 + core_dout) : 8'h3F;

  // Watchdog counts down from TIMEOUT-1; zero marks the final WAIT cycle
  assign timer_tc = (timer == '0);

  assign core_valid = (state == ISSUE);
  assign out_valid  = (state == OUT);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_dec, letter_idx};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Saturating count of consumed non-letters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept && !is_letter && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and pop decode
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || timer_tc) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= TW'(TIMEOUT - 1);
    end else if ((state == WAIT) && !timer_tc) begin
      timer <= timer - 1'b1;
    end
  end

  // Registered core-side and output-side datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_din    <= '0;
      core_dec    <= 1'b0;
      out_char    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (pop) begin
        core_din <= mem[rd_ptr][7:0];
        core_dec <= mem[rd_ptr][8];
      end
      // done takes priority over a coincident watchdog expiry
      if (state == WAIT) begin
        if (core_done) begin
          out_char <= result_char;
        end else if (timer_tc) begin
          out_char    <= 8'h3F;
          err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
